// File: rtl/frame_buf_wr_sched.sv
// Write-side frame-buffer scheduler: rotates a one-hot write pointer over
// NUM_BUF buffers, skipping the buffer the reader is scanning, and publishes
// the last completed frame on last_next_point for the read-side base loop.
// Optional build macro FRAME_BUF_STAT_EN adds frame_cnt/drop_cnt statistics.
module frame_buf_wr_sched #(
    parameter int unsigned NUM_BUF = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_vsync,
    input  logic        wr_enable,
    input  logic [4:0]  rd_curr_point,
    output logic [4:0]  wr_curr_point,
    output logic [4:0]  last_next_point,
    output logic        frame_done,
    output logic        collide
`ifdef FRAME_BUF_STAT_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam int unsigned PTR_W = 5;
    localparam int unsigned IDX_W = 3;
    localparam logic [PTR_W-1:0] BUF_MASK    = PTR_W'((1 << NUM_BUF) - 1);
    localparam logic [PTR_W-1:0] WR_RST_PTR  = PTR_W'(1);
    localparam logic [PTR_W-1:0] LAST_RST_PTR = PTR_W'(2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITING = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             vs_s1, vs_s2;
    logic             vs_rise;
    logic             rd_valid;
    logic [PTR_W-1:0] sel_point;
    logic [PTR_W-1:0] wr_nxt, last_nxt;
    logic             done_nxt, collide_nxt;

    // Rotate a one-hot pointer left by k positions inside the NUM_BUF ring.
    function automatic logic [PTR_W-1:0] rotl(input logic [PTR_W-1:0] p, input int k);
        logic [PTR_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(PTR_W); i++) begin
            if (i < int'(NUM_BUF)) begin
                r[IDX_W'((i + k) % int'(NUM_BUF))] = p[IDX_W'(i)];
            end
        end
        return r;
    endfunction

    // Two-flop vsync sampler; rising edge is a one-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
        end else begin
            vs_s1 <= wr_vsync;
            vs_s2 <= vs_s1;
        end
    end

    assign vs_rise = vs_s1 & ~vs_s2;

    // Read pointer is usable for exclusion only if one-hot and within the ring.
    assign rd_valid = (rd_curr_point != '0)
                    && ((rd_curr_point & (rd_curr_point - PTR_W'(1))) == '0)
                    && ((rd_curr_point & ~BUF_MASK) == '0);

    // Next write buffer: lowest rotation that avoids the reader; k=1 if reader unknown.
    always_comb begin
        sel_point = rotl(wr_curr_point, 1);
        if (rd_valid) begin
            for (int k = int'(NUM_BUF) - 1; k >= 1; k--) begin
                if (rotl(wr_curr_point, k) != rd_curr_point) begin
                    sel_point = rotl(wr_curr_point, k);
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt   = state;
        wr_nxt      = wr_curr_point;
        last_nxt    = last_next_point;
        done_nxt    = 1'b0;
        collide_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (vs_rise) begin
                    state_nxt = WRITING;
                end
            end
            WRITING: begin
                collide_nxt = (rd_curr_point == wr_curr_point);
                if (vs_rise && wr_enable) begin
                    last_nxt  = wr_curr_point;
                    done_nxt  = 1'b1;
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                wr_nxt    = sel_point;
                state_nxt = WRITING;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered pointers and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_curr_point   <= WR_RST_PTR;
            last_next_point <= LAST_RST_PTR;
            frame_done      <= 1'b0;
            collide         <= 1'b0;
        end else begin
            wr_curr_point   <= wr_nxt;
            last_next_point <= last_nxt;
            frame_done      <= done_nxt;
            collide         <= collide_nxt;
        end
    end

`ifdef FRAME_BUF_STAT_EN
    logic drop_evt;

    assign drop_evt = (state == WRITING) && vs_rise && !wr_enable;

    // Committed-frame and dropped-frame counters, free-running wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
            drop_cnt  <= 16'd0;
        end else begin
            if (done_nxt) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (drop_evt) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frame_buf_wr_sched.sv
// Scoreboard bench for frame_buf_wr_sched with NUM_BUF=3 and NUM_BUF=5 instances.
module tb_frame_buf_wr_sched;

    typedef struct packed {
        logic [4:0] last;
        logic [4:0] wr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vs3, en3, vs5, en5;
    logic [4:0] rd3, rd5;
    logic [4:0] wr3, last3, wr5, last5;
    logic       done3, coll3, done5, coll5;
`ifdef FRAME_BUF_STAT_EN
    logic [15:0] fc3, dc3, fc5, dc5;
`endif

    always #5 clk = ~clk;

    frame_buf_wr_sched #(.NUM_BUF(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .wr_vsync(vs3), .wr_enable(en3),
        .rd_curr_point(rd3), .wr_curr_point(wr3), .last_next_point(last3),
        .frame_done(done3), .collide(coll3)
`ifdef FRAME_BUF_STAT_EN
        , .frame_cnt(fc3), .drop_cnt(dc3)
`endif
    );

    frame_buf_wr_sched #(.NUM_BUF(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .wr_vsync(vs5), .wr_enable(en5),
        .rd_curr_point(rd5), .wr_curr_point(wr5), .last_next_point(last5),
        .frame_done(done5), .collide(coll5)
`ifdef FRAME_BUF_STAT_EN
        , .frame_cnt(fc5), .drop_cnt(dc5)
`endif
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q3[$];
    exp_t q5[$];
    bit   mon3_en = 1'b1;
    int   done3_cnt = 0;
    int   done5_cnt = 0;
    int   coll3_cnt = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int which, input logic [4:0] l, input logic [4:0] w);
        exp_t e;
        e.last = l;
        e.wr   = w;
        if (which == 3) q3.push_back(e);
        else            q5.push_back(e);
    endtask

    task automatic vpulse(input int which);
        @(negedge clk);
        if (which == 3) vs3 = 1'b1; else vs5 = 1'b1;
        repeat (4) @(negedge clk);
        if (which == 3) vs3 = 1'b0; else vs5 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (done3 === 1'b1) done3_cnt++;
        if (done5 === 1'b1) done5_cnt++;
        if (coll3 === 1'b1) coll3_cnt++;
    end

    // Monitor for NUM_BUF=3: one cycle after frame_done, pointers must match the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done3 === 1'b1 && mon3_en) begin
                @(negedge clk);
                check("done3_width", 16'(done3), 16'd0);
                if (q3.size() == 0) begin
                    check("done3_unexpected", 16'(1), 16'(0));
                end else begin
                    e = q3.pop_front();
                    check("last3", 16'(last3), 16'(e.last));
                    check("wr3", 16'(wr3), 16'(e.wr));
                end
            end
        end
    end

    // Monitor for NUM_BUF=5.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done5 === 1'b1) begin
                @(negedge clk);
                check("done5_width", 16'(done5), 16'd0);
                if (q5.size() == 0) begin
                    check("done5_unexpected", 16'(1), 16'(0));
                end else begin
                    e = q5.pop_front();
                    check("last5", 16'(last5), 16'(e.last));
                    check("wr5", 16'(wr5), 16'(e.wr));
                end
            end
        end
    end

    initial begin
        int         c0;
        bit         seen;
        logic [4:0] p;

        rst_n = 1'b0;
        vs3 = 1'b0; en3 = 1'b1; rd3 = 5'b00010;
        vs5 = 1'b0; en5 = 1'b1; rd5 = 5'b00000;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_wr3", 16'(wr3), 16'b00001);
        check("rst_last3", 16'(last3), 16'b00010);
        check("rst_done3", 16'(done3), 16'd0);
        check("rst_coll3", 16'(coll3), 16'd0);
        check("rst_wr5", 16'(wr5), 16'b00001);
        check("rst_last5", 16'(last5), 16'b00010);
        rst_n = 1'b1;
        @(negedge clk);

        // First rise only leaves IDLE
        vpulse(3);
        check("idle_done_cnt", 16'(done3_cnt), 16'd0);
        check("idle_wr3", 16'(wr3), 16'b00001);
        check("idle_last3", 16'(last3), 16'b00010);

        // Normal commits, reader on buffer 1
        push(3, 5'b00001, 5'b00100);
        vpulse(3);
        check("commit1_cnt", 16'(done3_cnt), 16'd1);
        push(3, 5'b00100, 5'b00001);
        vpulse(3);
        check("commit2_cnt", 16'(done3_cnt), 16'd2);

        // Disabled: hold and overwrite
        en3 = 1'b0;
        vpulse(3);
        check("hold_cnt", 16'(done3_cnt), 16'd2);
        check("hold_wr3", 16'(wr3), 16'b00001);
        check("hold_last3", 16'(last3), 16'b00100);
`ifdef FRAME_BUF_STAT_EN
        check("drop_cnt", dc3, 16'd1);
        check("frame_cnt_a", fc3, 16'd2);
`endif
        en3 = 1'b1;
        push(3, 5'b00001, 5'b00100);
        vpulse(3);
        check("reenable_cnt", 16'(done3_cnt), 16'd3);
`ifdef FRAME_BUF_STAT_EN
        check("frame_cnt_b", fc3, 16'd3);
`endif

        // Collision for 3 cycles
        c0 = coll3_cnt;
        @(negedge clk);
        rd3 = 5'b00100;
        repeat (3) @(negedge clk);
        rd3 = 5'b00010;
        repeat (3) @(negedge clk);
        check("collide_cycles", 16'(coll3_cnt - c0), 16'd3);
        check("coll_wr3", 16'(wr3), 16'b00100);
        check("coll_last3", 16'(last3), 16'b00001);

        // Reset during COMMIT
        mon3_en = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        vs3 = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done3 === 1'b1) seen = 1'b1;
        end
        check("commit_seen", 16'(seen), 16'd1);
        rst_n = 1'b0;
        vs3 = 1'b0;
        #1;
        check("midrst_wr3", 16'(wr3), 16'b00001);
        check("midrst_last3", 16'(last3), 16'b00010);
        check("midrst_done3", 16'(done3), 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon3_en = 1'b1;
        c0 = done3_cnt;
        vpulse(3);
        check("post_rst_idle_cnt", 16'(done3_cnt - c0), 16'd0);
        check("post_rst_wr3", 16'(wr3), 16'b00001);
        push(3, 5'b00001, 5'b00100);
        vpulse(3);
        check("post_rst_commit_cnt", 16'(done3_cnt - c0), 16'd1);

        // Invalid (non one-hot) reader pointer takes k=1
        push(3, 5'b00100, 5'b00001);
        vpulse(3);
        rd3 = 5'b01010;
        push(3, 5'b00001, 5'b00010);
        vpulse(3);

        // NUM_BUF=5: walk to the top buffer with no reader exclusion
        vpulse(5);
        p = 5'b00001;
        repeat (4) begin
            push(5, p, 5'(p << 1));
            vpulse(5);
            p = 5'(p << 1);
        end
        // Wrap with reader on buffer 0: skips to buffer 1
        rd5 = 5'b00001;
        push(5, 5'b10000, 5'b00010);
        vpulse(5);
        rd5 = 5'b00000;
        p = 5'b00010;
        repeat (3) begin
            push(5, p, 5'(p << 1));
            vpulse(5);
            p = 5'(p << 1);
        end
        // Wrap with no valid reader: plain rotation
        push(5, 5'b10000, 5'b00001);
        vpulse(5);

        repeat (5) @(negedge clk);
        check("q3_drained", 16'(q3.size()), 16'd0);
        check("q5_drained", 16'(q5.size()), 16'd0);
        check("done5_total", 16'(done5_cnt), 16'd9);
        check("coll5_none", 16'(coll5), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
